// File: rtl/fp_pool.sv
// fp_pool: binary32 average/max pooling over WINDOW samples.
// Input and output use valid/ready handshakes. AVG scales each sample by
// RECIP and accumulates; MAX keeps a running maximum. The window mode is
// latched on the first sample. Results are held in HOLD until the
// downstream handshake completes.
module fp_pool #(
    parameter int          WINDOW = 4,
    parameter logic [31:0] RECIP  = 32'h3E800000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int             CW   = $clog2(WINDOW) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WINDOW - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state, state_n;
    logic [31:0]   acc, acc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mode_q, mode_n;
    logic [31:0]   data_n;
    logic [31:0]   scaled;
    logic [31:0]   upd;

    // Round-to-nearest-even binary32 multiply; subnormals flush to zero.
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        p;
        logic signed [10:0] e;
        logic [23:0]        m;
        logic               g, st;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 11'(a[30:23]) + 11'(b[30:23]) - 11'sd127;
        if (p[47]) begin
            m  = {1'b0, p[46:24]};
            g  = p[23];
            st = |p[22:0];
            e  = e + 11'sd1;
        end else begin
            m  = {1'b0, p[45:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) begin
            e = e + 11'sd1;
            m = 24'd0;
        end
        if (e >= 11'sd255) return {s, 8'hFF, 23'b0};
        if (e <= 11'sd0) return {s, 31'b0};
        return {s, e[7:0], m[22:0]};
    endfunction

    // Round-to-nearest-even binary32 add with guard/round/sticky bits.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [26:0]        mx, my;
        logic [27:0]        s;
        logic signed [10:0] e;
        logic [7:0]         d;
        logic [23:0]        m;
        logic               g, st;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (d >= 8'd27) begin
            my = 27'd1;
        end else begin
            for (int i = 0; i < 26; i++)
                if (8'(i) < d) my = {1'b0, my[26:2], my[1] | my[0]};
        end
        e = 11'(x[30:23]);
        if (x[31] == y[31]) begin
            s = 28'(mx) + 28'(my);
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 11'sd1;
            end
        end else begin
            s = 28'(mx) - 28'(my);
            if (s == 28'd0) return 32'h0;
            for (int i = 0; i < 27; i++)
                if (!s[26]) begin
                    s = s << 1;
                    e = e - 11'sd1;
                end
        end
        m  = {1'b0, s[25:3]};
        g  = s[2];
        st = |s[1:0];
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) begin
            e = e + 11'sd1;
            m = 24'd0;
        end
        if (e >= 11'sd255) return {x[31], 8'hFF, 23'b0};
        if (e <= 11'sd0) return {x[31], 31'b0};
        return {x[31], e[7:0], m[22:0]};
    endfunction

    // Sign-magnitude "a strictly greater than b"; +0 and -0 are equal.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return ~a[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    assign in_ready  = (state == ACCUM) & ~rst;
    assign out_valid = (state == HOLD);
    assign scaled    = fpmul(in_data, RECIP);

    // Next-state and datapath update for accepts and output handshake.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        mode_n  = mode_q;
        data_n  = out_data;
        upd     = acc;
        case (state)
            ACCUM: begin
                if (in_valid) begin
                    if (cnt == '0) begin
                        mode_n = mode;
                        upd    = mode ? in_data : scaled;
                    end else if (mode_q) begin
                        upd = fp_gt(in_data, acc) ? in_data : acc;
                    end else begin
                        upd = fp_add(acc, scaled);
                    end
                    if (cnt == LAST) begin
                        data_n  = upd;
                        acc_n   = 32'h0;
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else begin
                        acc_n = upd;
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_n = ACCUM;
            end
            default: state_n = ACCUM;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACCUM;
            acc      <= 32'h0;
            cnt      <= '0;
            mode_q   <= 1'b0;
            out_data <= 32'h0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            mode_q   <= mode_n;
            out_data <= data_n;
        end
    end

endmodule

// File: tb/tb_fp_pool.sv
// Directed bench for fp_pool at WINDOW = 4, 8 and 1.
module tb_fp_pool;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [31:0] in_data;
    logic        out_ready;
    logic        v4, v8, v1;
    logic        ir4, ir8, ir1;
    logic        ov4, ov8, ov1;
    logic [31:0] od4, od8, od1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_pool u4 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(v4), .in_ready(ir4),
        .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
    );

    fp_pool #(.WINDOW(8), .RECIP(32'h3E000000)) u8 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(v8), .in_ready(ir8),
        .in_data(in_data), .out_valid(ov8), .out_ready(out_ready), .out_data(od8)
    );

    fp_pool #(.WINDOW(1), .RECIP(32'h3F800000)) u1 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(v1), .in_ready(ir1),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", tag, got, exp);
        end
    endtask

    // One back-to-back window on the WINDOW=4 instance with out_ready=1.
    task automatic run4(input string tag, input logic m0, input logic mr,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic [31:0] exp);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) chk({tag, "_early"}, 32'(ov4), 32'd0);
            mode    = (i == 0) ? m0 : mr;
            in_data = d[i];
            v4      = 1'b1;
        end
        @(negedge clk);
        v4 = 1'b0;
        chk({tag, "_vld"}, 32'(ov4), 32'd1);
        chk({tag, "_data"}, od4, exp);
        chk({tag, "_rdy_hold"}, 32'(ir4), 32'd0);
        @(negedge clk);
        chk({tag, "_vld_drop"}, 32'(ov4), 32'd0);
        chk({tag, "_rdy_back"}, 32'(ir4), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; mode = 1'b0; in_data = 32'h0; out_ready = 1'b1;
        v4 = 1'b0; v8 = 1'b0; v1 = 1'b0;

        // reset state
        #12;
        chk("rst_rdy", 32'(ir4), 32'd0);
        chk("rst_vld", 32'(ov4), 32'd0);
        chk("rst_data", od4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 32'(ir4), 32'd1);

        // averaging and max pooling
        run4("avg", 1'b0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40200000);
        run4("max_mix", 1'b1, 1'b1, 32'hBF800000, 32'h40600000, 32'hC0E00000, 32'h3F000000, 32'h40600000);
        run4("max_neg", 1'b1, 1'b1, 32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000, 32'hBF000000);
        run4("avg_sgn", 1'b0, 1'b0, 32'h40800000, 32'hC0000000, 32'h40400000, 32'hBF800000, 32'h3F800000);
        run4("avg_zero", 1'b0, 1'b0, 32'h40800000, 32'hC0000000, 32'h3F800000, 32'hC0400000, 32'h00000000);

        // backpressure: result held, offered samples ignored
        out_ready = 1'b0;
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_data = 32'h40800000;
            v4 = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_data = 32'h41200000;
            chk("bp_vld", 32'(ov4), 32'd1);
            chk("bp_data", od4, 32'h40800000);
            chk("bp_rdy", 32'(ir4), 32'd0);
        end
        v4 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(ov4), 32'd0);
        run4("bp_after", 1'b0, 1'b0, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);

        // mode latched on first sample
        run4("mode_latch", 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F800000, 32'h40000000);

        // asynchronous reset mid-window
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mode = 1'b0;
            in_data = 32'h41200000;
            v4 = 1'b1;
        end
        @(negedge clk);
        v4 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 32'(ov4), 32'd0);
        chk("arst_rdy", 32'(ir4), 32'd0);
        chk("arst_data", od4, 32'h0);
        #1 rst = 1'b0;
        run4("arst_win", 1'b0, 1'b0, 32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000);

        // WINDOW=8 with gaps
        n = 0;
        mode = 1'b0;
        for (int c = 0; c < 300 && n < 8; c++) begin
            @(negedge clk);
            chk("w8_early", 32'(ov8), 32'd0);
            in_data = 32'h3F800000;
            v8 = 1'($urandom_range(0, 1));
            if (v8) n++;
        end
        @(negedge clk);
        v8 = 1'b0;
        chk("w8_count", 32'(n), 32'd8);
        chk("w8_vld", 32'(ov8), 32'd1);
        chk("w8_data", od8, 32'h3F800000);
        @(negedge clk);
        chk("w8_drop", 32'(ov8), 32'd0);

        // WINDOW=1
        @(negedge clk);
        in_data = 32'h40A00000;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        chk("w1_vld", 32'(ov1), 32'd1);
        chk("w1_data", od1, 32'h40A00000);
        @(negedge clk);
        chk("w1_drop", 32'(ov1), 32'd0);
        chk("w1_rdy", 32'(ir1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
